// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator character interface:
// ASCII codes, the serializer state encoding and the double-dabble digit adjust.
package calc_pkg;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_HASH  = 8'h23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_SIGN,
        ST_SKIP,
        ST_EMIT,
        ST_TERM,
        ST_FIN
    } ser_state_t;

    // Shift-add-3 correction applied to a BCD digit before each left shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per cycle, MSB first.
// The first shift happens on the accepting edge, so a conversion takes exactly WIDTH cycles.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  ready,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [DIGITS*4-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;

    logic [DIGITS*4-1:0] src;
    logic [DIGITS*4-1:0] shifted;
    logic [3:0]          nib;
    logic                carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Adjust every digit, then shift the whole BCD vector left by one with the next binary bit.
    always_comb begin
        src     = busy_q ? bcd_q : '0;
        carry   = busy_q ? bin_q[WIDTH-1] : value[WIDTH-1];
        shifted = '0;
        nib     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib                = dabble_adj(src[i*4 +: 4]);
            shifted[i*4 +: 4]  = {nib[2:0], carry};
            carry              = nib[3];
        end
    end

    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        if (busy_q) begin
            bcd_d = shifted;
            bin_d = bin_q << 1;
            rem_d = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        end else if (start) begin
            bcd_d   = shifted;
            bin_d   = value << 1;
            rem_d   = CNT_W'(WIDTH - 1);
            busy_d  = (WIDTH > 1);
            ready_d = (WIDTH == 1);
        end
    end

    assign busy  = busy_q;
    assign ready = ready_q;
    assign bcd   = bcd_q;

endmodule

// File: rtl/result_char_serializer.sv
// Streams a binary result as ASCII decimal, MSD first, terminated by TERM_CHAR.
// Define NEG_SIGN_EN to treat result as two's complement and prefix negatives with '-'.
//
//  state | meaning
//  IDLE  | waiting for start; captures result
//  CONV  | double-dabble conversion running
//  SIGN  | presenting '-' (NEG_SIGN_EN only)
//  SKIP  | stepping the digit pointer past leading zeros
//  EMIT  | presenting digit at pointer
//  TERM  | presenting terminator
//  FIN   | one-cycle done pulse
module result_char_serializer
    import calc_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter int         DIGITS    = 5,
    parameter logic [7:0] TERM_CHAR = CH_HASH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             done
);

    localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;
    localparam int PTR_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(DIGITS - 1);

    if (DIGITS < MIN_DIGITS) begin : g_digits_check
        $error("result_char_serializer: DIGITS too small to hold a WIDTH-bit value");
    end

    ser_state_t          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_char_q, out_char_d;

    logic [WIDTH-1:0]    magnitude;
    logic [DIGITS*4-1:0] bcd_digits;
    logic                bcd_start, bcd_busy, bcd_ready;
    logic                handshake;
    logic                skip_more;
    logic [3:0]          cur_digit, out_digit;

`ifdef NEG_SIGN_EN
    logic neg_q, neg_d;
    // Negating the most-negative value wraps back to 2^(WIDTH-1), which is its correct magnitude.
    assign magnitude = result[WIDTH-1] ? (~result + 1'b1) : result;
`else
    assign magnitude = result;
`endif

    assign bcd_start = (state_q == ST_IDLE) && start && !bcd_busy;
    assign handshake = out_valid_q && out_ready;
    assign cur_digit = bcd_digits[{ptr_q, 2'b00} +: 4];
    assign out_digit = bcd_digits[{ptr_d, 2'b00} +: 4];
    assign skip_more = (cur_digit == 4'd0) && (ptr_q != '0);

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (bcd_start),
        .value  (magnitude),
        .busy   (bcd_busy),
        .ready  (bcd_ready),
        .bcd    (bcd_digits)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
`ifdef NEG_SIGN_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
`ifdef NEG_SIGN_EN
            neg_q       <= neg_d;
`endif
        end
    end

    // Leaving CONV or SIGN already evaluates the top slot, so a nonzero MSD costs no SKIP cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
`ifdef NEG_SIGN_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bcd_start) begin
                    state_d = ST_CONV;
                    ptr_d   = PTR_TOP;
`ifdef NEG_SIGN_EN
                    neg_d   = result[WIDTH-1];
`endif
                end
            end
            ST_CONV: begin
                if (bcd_ready) begin
`ifdef NEG_SIGN_EN
                    if (neg_q) begin
                        state_d = ST_SIGN;
                    end else
`endif
                    if (skip_more) begin
                        state_d = ST_SKIP;
                        ptr_d   = ptr_q - 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
            end
`ifdef NEG_SIGN_EN
            ST_SIGN: begin
                if (handshake) begin
                    if (skip_more) begin
                        state_d = ST_SKIP;
                        ptr_d   = ptr_q - 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
            end
`endif
            ST_SKIP: begin
                if (skip_more) begin
                    ptr_d = ptr_q - 1'b1;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (handshake) begin
                    if (ptr_q == '0) begin
                        state_d = ST_TERM;
                    end else begin
                        ptr_d = ptr_q - 1'b1;
                    end
                end
            end
            ST_TERM: begin
                if (handshake) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The character register is loaded from the next state so out_valid never bubbles between chars.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_FIN);
        out_valid_d = 1'b0;
        out_char_d  = 8'h00;
        case (state_d)
`ifdef NEG_SIGN_EN
            ST_SIGN: begin
                out_valid_d = 1'b1;
                out_char_d  = CH_MINUS;
            end
`endif
            ST_EMIT: begin
                out_valid_d = 1'b1;
                out_char_d  = CH_ZERO + {4'h0, out_digit};
            end
            ST_TERM: begin
                out_valid_d = 1'b1;
                out_char_d  = TERM_CHAR;
            end
            default: ;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;

endmodule
